// File: rtl/fetch_pkg.sv
// Shared types for the instruction fetch controller: FSM states, the
// {pc, instruction} entry carried toward decode, and the default halt encoding.
// No ports; imported by fetch_fifo and fetch_controller.
package fetch_pkg;

  localparam int FETCH_PC_WIDTH          = 32;
  localparam int FETCH_INSTRUCTION_WIDTH = 32;

  // Instruction encoding that stops fetching (all ones).
  localparam logic [FETCH_INSTRUCTION_WIDTH-1:0] HALT_WORD_DEFAULT = '1;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    RUN    = 2'd1,
    HALTED = 2'd2
  } fetch_state_t;

  typedef struct packed {
    logic [FETCH_PC_WIDTH-1:0]          pc;
    logic [FETCH_INSTRUCTION_WIDTH-1:0] instruction;
  } fetch_entry_t;

endpackage

// File: rtl/fetch_fifo.sv
// Purpose: synchronous FIFO of fetch entries between the PC sequencer and decode.
// Latency: a push is visible at rdata the cycle after it is written into an empty FIFO.
// Backpressure: push is dropped when full unless a pop happens the same cycle; clear wins over push/pop.
// Ports: clk, rst (sync, active high), push/wdata, pop/rdata, clear, count, full, empty.
module fetch_fifo
  import fetch_pkg::*;
#(
  parameter int DEPTH = 2
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     push,
  input  fetch_entry_t             wdata,
  input  logic                     pop,
  output fetch_entry_t             rdata,
  input  logic                     clear,
  output logic [$clog2(DEPTH):0]   count,
  output logic                     full,
  output logic                     empty
);

  localparam int AW = $clog2(DEPTH);

  fetch_entry_t          mem [DEPTH];
  logic [AW-1:0]         rd_ptr;
  logic [AW-1:0]         wr_ptr;
  logic                  do_push;
  logic                  do_pop;

  assign empty   = (count == '0);
  assign full    = (count == ($clog2(DEPTH)+1)'(DEPTH));
  assign do_pop  = pop && !empty;
  // A full FIFO can still accept a write when the head leaves in the same cycle.
  assign do_push = push && (!full || do_pop);
  assign rdata   = mem[rd_ptr];

  always_ff @(posedge clk) begin
    if (do_push && !clear) begin
      mem[wr_ptr] <= wdata;
    end
  end

  always_ff @(posedge clk) begin
    if (rst || clear) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= '0;
    end else begin
      // DEPTH is a power of two, so the pointers wrap naturally.
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
      case ({do_push, do_pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

endmodule

// File: rtl/fetch_controller.sv
// Purpose: owns the PC, fetches one word per cycle from the combinational instruction
//   memory and queues {pc, instruction} toward decode; handles redirects, halt word, end of memory.
// Latency: fetched word appears on out_* one cycle after its fetch (two edges after start/redirect).
// Backpressure: out_valid/out_ready; fetch stalls while the buffer is full and not draining.
// Ports: clk, rst, start | imem_pc -> imem_instruction | redirect_valid/target |
//   out_valid/out_ready/out_pc/out_instruction | running, halted, error, fetch_count.
module fetch_controller
  import fetch_pkg::*;
#(
  parameter int PC_WIDTH          = FETCH_PC_WIDTH,
  parameter int INSTRUCTION_WIDTH = FETCH_INSTRUCTION_WIDTH,
  parameter int MEMORY_SIZE       = 1024,
  parameter int RESET_PC          = 0,
  parameter int FIFO_DEPTH        = 2,
  parameter logic [INSTRUCTION_WIDTH-1:0] HALT_WORD = HALT_WORD_DEFAULT
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic                          start,
  output logic [PC_WIDTH-1:0]           imem_pc,
  input  logic [INSTRUCTION_WIDTH-1:0]  imem_instruction,
  input  logic                          redirect_valid,
  input  logic [PC_WIDTH-1:0]           redirect_target,
  output logic                          out_valid,
  input  logic                          out_ready,
  output logic [PC_WIDTH-1:0]           out_pc,
  output logic [INSTRUCTION_WIDTH-1:0]  out_instruction,
  output logic                          running,
  output logic                          halted,
  output logic                          error,
  output logic [31:0]                   fetch_count
);

  localparam logic [PC_WIDTH-1:0] LAST_PC  = PC_WIDTH'(MEMORY_SIZE - 1);
  localparam logic [PC_WIDTH-1:0] START_PC = PC_WIDTH'(RESET_PC);

  fetch_state_t                 state_q, state_d;
  logic [PC_WIDTH-1:0]          pc_q, pc_d;
  logic                         error_q, error_d;
  logic [31:0]                  fetch_count_q, fetch_count_d;

  logic                         fifo_push;
  logic                         fifo_pop;
  logic                         fifo_clear;
  logic                         fifo_full;
  logic                         fifo_empty;
  fetch_entry_t                 fifo_wdata;
  fetch_entry_t                 fifo_rdata;
  // Occupancy is exposed by the FIFO; the controller only needs full/empty.
  logic [$clog2(FIFO_DEPTH):0]  fifo_count_unused;
  logic                         redirect_legal;

  // Extra bit so a target that is exactly MEMORY_SIZE compares correctly at any PC width.
  assign redirect_legal = ({1'b0, redirect_target} < (PC_WIDTH+1)'(MEMORY_SIZE));
  assign fifo_pop       = out_valid && out_ready;
  assign fifo_wdata     = '{pc: pc_q, instruction: imem_instruction};

  fetch_fifo #(
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk   (clk),
    .rst   (rst),
    .push  (fifo_push),
    .wdata (fifo_wdata),
    .pop   (fifo_pop),
    .rdata (fifo_rdata),
    .clear (fifo_clear),
    .count (fifo_count_unused),
    .full  (fifo_full),
    .empty (fifo_empty)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q       <= IDLE;
      pc_q          <= START_PC;
      error_q       <= 1'b0;
      fetch_count_q <= '0;
    end else begin
      state_q       <= state_d;
      pc_q          <= pc_d;
      error_q       <= error_d;
      fetch_count_q <= fetch_count_d;
    end
  end

  always_comb begin
    state_d       = state_q;
    pc_d          = pc_q;
    error_d       = error_q;
    fetch_count_d = fetch_count_q;
    fifo_push     = 1'b0;
    fifo_clear    = 1'b0;

    case (state_q)
      IDLE: begin
        if (start) begin
          state_d       = RUN;
          pc_d          = START_PC;
          fifo_clear    = 1'b1;
          error_d       = 1'b0;
          fetch_count_d = '0;
        end
      end

      RUN: begin
        if (redirect_valid) begin
          // The head is discarded even if decode takes it this cycle.
          fifo_clear = 1'b1;
          if (redirect_legal) begin
            pc_d = redirect_target;
          end else begin
            error_d = 1'b1;
            state_d = HALTED;
          end
        end else if (!fifo_full || fifo_pop) begin
          fifo_push     = 1'b1;
          fetch_count_d = fetch_count_q + 32'd1;
          // The PC parks on the last word instead of wrapping to 0.
          if (pc_q != LAST_PC) pc_d = pc_q + 1'b1;
          if (imem_instruction == HALT_WORD || pc_q == LAST_PC) state_d = HALTED;
        end
      end

      HALTED: begin
        if (start) begin
          state_d       = RUN;
          pc_d          = START_PC;
          fifo_clear    = 1'b1;
          error_d       = 1'b0;
          fetch_count_d = '0;
        end else if (redirect_valid) begin
          fifo_clear = 1'b1;
          if (redirect_legal) begin
            pc_d    = redirect_target;
            state_d = RUN;
          end else begin
            error_d = 1'b1;
          end
        end
      end

      default: state_d = IDLE;
    endcase
  end

  assign imem_pc         = pc_q;
  assign out_valid       = !fifo_empty;
  // Zero the data when nothing is queued so the idle bus is quiet and deterministic.
  assign out_pc          = out_valid ? fifo_rdata.pc          : '0;
  assign out_instruction = out_valid ? fifo_rdata.instruction : '0;
  assign running         = (state_q == RUN);
  assign halted          = (state_q == HALTED);
  assign error           = error_q;
  assign fetch_count     = fetch_count_q;

endmodule

// File: tb/tb_fetch_controller.sv
module tb_fetch_controller;

  localparam int MEM   = 1024;
  localparam int DEPTH = 2;
  localparam logic [31:0] HALT = 32'hFFFF_FFFF;
  localparam int S_IDLE = 0, S_RUN = 1, S_HALTED = 2;

  typedef struct {
    int          pc;
    logic [31:0] ins;
  } ent_t;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        start = 1'b0;
  logic [31:0] imem_pc;
  logic [31:0] imem_instruction;
  logic        redirect_valid = 1'b0;
  logic [31:0] redirect_target = '0;
  logic        out_valid;
  logic        out_ready = 1'b0;
  logic [31:0] out_pc;
  logic [31:0] out_instruction;
  logic        running, halted, error;
  logic [31:0] fetch_count;

  logic [31:0] mem [MEM];
  int          n_cmp = 0;
  int          n_bad = 0;
  bit          chk_en = 0;
  int          delivered[$];

  // Reference model state
  int          m_state;
  int          m_pc;
  bit          m_err;
  int          m_cnt;
  ent_t        m_q[$];

  always #5 clk = ~clk;

  assign imem_instruction = (imem_pc < MEM) ? mem[imem_pc[9:0]] : 32'h0;

  fetch_controller dut (
    .clk              (clk),
    .rst              (rst),
    .start            (start),
    .imem_pc          (imem_pc),
    .imem_instruction (imem_instruction),
    .redirect_valid   (redirect_valid),
    .redirect_target  (redirect_target),
    .out_valid        (out_valid),
    .out_ready        (out_ready),
    .out_pc           (out_pc),
    .out_instruction  (out_instruction),
    .running          (running),
    .halted           (halted),
    .error            (error),
    .fetch_count      (fetch_count)
  );

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Behavioural model: what the fetch stream must look like, one clock edge at a time.
  always @(posedge clk) begin
    bit   pop;
    ent_t e;
    if (rst) begin
      m_state = S_IDLE; m_pc = 0; m_err = 0; m_cnt = 0; m_q.delete();
    end else begin
      pop = (m_q.size() > 0) && out_ready;
      if (m_state != S_RUN && start) begin
        m_state = S_RUN; m_pc = 0; m_err = 0; m_cnt = 0; m_q.delete();
      end else if (m_state != S_IDLE && redirect_valid) begin
        m_q.delete();
        if (redirect_target < MEM) begin
          m_pc = int'(redirect_target); m_state = S_RUN;
        end else begin
          m_err = 1; m_state = S_HALTED;
        end
      end else if (m_state != S_IDLE) begin
        if (pop) void'(m_q.pop_front());
        if (m_state == S_RUN && m_q.size() < DEPTH) begin
          e.pc = m_pc; e.ins = mem[m_pc];
          m_q.push_back(e);
          m_cnt++;
          if (e.ins == HALT || m_pc == MEM - 1) m_state = S_HALTED;
          if (m_pc != MEM - 1) m_pc++;
        end
      end
    end
  end

  // Single compare process: every cycle once reset has been applied.
  always @(negedge clk) begin
    if (chk_en) begin
      check("out_valid", out_valid, m_q.size() != 0);
      if (m_q.size() != 0) begin
        check("out_pc", out_pc, m_q[0].pc);
        check("out_instruction", out_instruction, m_q[0].ins);
      end
      check("running", running, m_state == S_RUN);
      check("halted", halted, m_state == S_HALTED);
      check("error", error, m_err);
      check("fetch_count", fetch_count, m_cnt);
      check("imem_pc", imem_pc, m_pc);
    end
  end

  always @(negedge clk) begin
    if (out_valid === 1'b1 && out_ready) delivered.push_back(int'(out_pc));
  end

  task automatic step();
    @(posedge clk);
    #2;
    start = 0; redirect_valid = 0; rst = 0;
  endtask

  task automatic fill_mem(input int halt_one_in);
    for (int i = 0; i < MEM; i++) begin
      mem[i] = $urandom & 32'h7FFF_FFFF;
      if (halt_one_in > 0 && $urandom_range(halt_one_in - 1) == 0) mem[i] = HALT;
    end
  endtask

  initial begin
    fill_mem(0);
    @(posedge clk); @(posedge clk); #2;
    rst = 0; chk_en = 1;

    // Reset state
    check("rst_out_valid", out_valid, 0);
    check("rst_running", running, 0);
    check("rst_halted", halted, 0);
    check("rst_error", error, 0);
    check("rst_fetch_count", fetch_count, 0);
    check("rst_imem_pc", imem_pc, 0);
    check("rst_out_pc", out_pc, 0);

    // A: short program ending in the halt word, decode always ready
    mem[0] = 32'h1111_1111; mem[1] = 32'h2222_2222; mem[2] = 32'h3333_3333; mem[3] = HALT;
    delivered.delete();
    out_ready = 1; start = 1;
    step();
    check("A_running", running, 1);
    check("A_first_cycle_empty", out_valid, 0);
    step();
    check("A_first_valid", out_valid, 1);
    check("A_first_pc", out_pc, 0);
    check("A_first_ins", out_instruction, 32'h1111_1111);
    repeat (6) step();
    check("A_halted", halted, 1);
    check("A_fetch_count", fetch_count, 4);
    check("A_drained", out_valid, 0);
    check("A_n_delivered", delivered.size(), 4);
    for (int i = 0; i < delivered.size(); i++) check("A_order", delivered[i], i);

    // B: decode stalled, FIFO fills with 0,1, then drains in order
    fill_mem(0);
    out_ready = 0; start = 1;
    repeat (4) step();
    check("B_imem_pc_hold", imem_pc, 2);
    check("B_head_pc", out_pc, 0);
    delivered.delete();
    out_ready = 1;
    repeat (20) step();
    check("B_n_delivered", delivered.size(), 20);
    for (int i = 0; i < delivered.size(); i++) check("B_order", delivered[i], i);

    // C: redirect flushes buffered 5,6
    out_ready = 0; redirect_valid = 1; redirect_target = 5;
    repeat (4) step();
    check("C_head5", out_pc, 5);
    check("C_imem_pc7", imem_pc, 7);
    redirect_valid = 1; redirect_target = 100;
    step();
    check("C_bubble", out_valid, 0);
    check("C_imem_pc100", imem_pc, 100);
    delivered.delete();
    out_ready = 1;
    repeat (3) step();
    check("C_n_delivered", delivered.size(), 2);
    if (delivered.size() >= 2) begin
      check("C_first100", delivered[0], 100);
      check("C_second101", delivered[1], 101);
    end

    // D: out-of-range redirect, then restart
    redirect_valid = 1; redirect_target = MEM;
    step();
    check("D_error", error, 1);
    check("D_halted", halted, 1);
    check("D_empty", out_valid, 0);
    start = 1;
    step();
    check("D_error_clear", error, 0);
    check("D_restart_pc", imem_pc, 0);
    step();
    check("D_restart_head", out_pc, 0);

    // E: no halt word, run to end of memory
    rst = 1;
    step();
    fill_mem(0);
    delivered.delete();
    out_ready = 1; start = 1;
    step();
    for (int i = 0; i < 1100 && halted !== 1'b1; i++) step();
    check("E_halted_in_time", halted, 1);
    repeat (4) step();
    check("E_imem_pc_end", imem_pc, MEM - 1);
    check("E_fetch_count", fetch_count, MEM);
    check("E_n_delivered", delivered.size(), MEM);
    if (delivered.size() > 0) check("E_last_pc", delivered[delivered.size()-1], MEM - 1);

    // F: reset mid-run with two entries buffered
    out_ready = 0; start = 1;
    repeat (4) step();
    check("F_buffered", fetch_count, 2);
    rst = 1;
    step();
    check("F_out_valid", out_valid, 0);
    check("F_running", running, 0);
    check("F_halted", halted, 0);
    check("F_imem_pc", imem_pc, 0);
    check("F_fetch_count", fetch_count, 0);
    check("F_out_pc", out_pc, 0);
    check("F_out_instruction", out_instruction, 0);

    // Random phase: model-checked every cycle
    fill_mem(25);
    for (int c = 0; c < 3000; c++) begin
      out_ready = ($urandom_range(2) != 0);
      start     = ($urandom_range(39) == 0);
      rst       = ($urandom_range(499) == 0);
      if ($urandom_range(14) == 0) begin
        redirect_valid = 1;
        case ($urandom_range(7))
          0:       redirect_target = MEM + $urandom_range(99);
          1:       redirect_target = MEM - 1 - $urandom_range(3);
          default: redirect_target = $urandom_range(MEM - 1);
        endcase
      end
      if (c % 1000 == 999) fill_mem(25);
      step();
    end
    out_ready = 1;
    repeat (10) step();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/fetch_controller.md
Name: fetch_controller

Overview:
Sequences the combinational instruction memory. It owns the PC, issues one word-addressed fetch per cycle and buffers fetched {pc, instruction} pairs in a small FIFO toward decode with a valid/ready handshake. It also handles branch redirects, halt-word detection and end-of-memory stop. It sits between instructionMemory and the decode stage of the vectorized CPU.

Parameters:
PC_WIDTH, 32, PC width; the PC is a word index into instruction memory
INSTRUCTION_WIDTH, 32, instruction word width
MEMORY_SIZE, 1024, number of instruction words; legal PC range is 0..MEMORY_SIZE-1
RESET_PC, 0, PC loaded on reset and on start
FIFO_DEPTH, 2, output buffer entries (power of two, ≥2)
HALT_WORD, all ones, instruction encoding that stops fetching

Ports:
clk  in  1  single clock, rising edge
rst  in  1  synchronous, active-high reset
start  in  1  pulse; IDLE -> RUN, PC <= RESET_PC
imem_pc  out  PC_WIDTH  address to instructionMemory (equals the PC register)
imem_instruction  in  INSTRUCTION_WIDTH  combinational read data for imem_pc
redirect_valid  in  1  branch or jump taken, one-cycle pulse
redirect_target  in  PC_WIDTH  new PC
out_valid  out  1  FIFO head valid
out_ready  in  1  decode accepts the head
out_pc  out  PC_WIDTH  PC of the head entry
out_instruction  out  INSTRUCTION_WIDTH  head instruction
running  out  1  state == RUN
halted  out  1  state == HALTED
error  out  1  sticky; set by an out-of-range redirect
fetch_count  out  32  number of words pushed since start (wraps)

Behaviour:
- Reset (rst=1 at a clk edge) overrides everything:
  - state=IDLE, PC=RESET_PC, FIFO emptied.
  - out_valid=0, out_pc=0, out_instruction=0, running=0, halted=0, error=0, fetch_count=0.
  - Reset mid-run discards all buffered entries.
- States: IDLE, RUN, HALTED.
  - IDLE -> RUN on start. All other inputs are ignored in IDLE.
  - RUN -> HALTED when a pushed word equals HALT_WORD, or when the pushed word's PC == MEMORY_SIZE-1.
  - HALTED -> RUN on a legal redirect (PC <= target).
  - HALTED -> RUN on start: PC <= RESET_PC, FIFO cleared, error cleared, fetch_count cleared.
- pop = out_valid & out_ready.
- push (RUN only, no redirect this cycle) = (count < FIFO_DEPTH) | pop.
  - On push: the entry {PC, imem_instruction} is written and PC <= PC+1.
  - The entry is visible at out_* the next cycle when the FIFO was empty. Fetch-to-out_valid latency is 1 cycle.
- Simultaneous push and pop on a full FIFO is allowed; count is unchanged.
- Redirect priority, highest first: rst > start (HALTED/IDLE) > redirect > push/pop.
  - Legal redirect (target < MEMORY_SIZE): FIFO flushed including the head, even if popped the same cycle. No push that cycle; PC <= target.
  - out_valid=0 the cycle after a redirect; the first post-redirect word is valid at the second edge.
- Illegal redirect (target >= MEMORY_SIZE): FIFO flushed, error=1, state=HALTED, PC unchanged.
- HALT_WORD is pushed and delivered to decode; nothing after it is fetched. The FIFO drains normally while HALTED.
- End of memory: the PC never wraps past MEMORY_SIZE-1. After that word is pushed, state=HALTED and PC holds MEMORY_SIZE-1.
- fetch_count increments by 1 per push.
- out_* stay stable while out_valid=1 and out_ready=0.

Decomposition:
- Package fetch_pkg: fetch_state_t enum {IDLE, RUN, HALTED}, fetch_entry_t struct {pc, instruction}, HALT_WORD default constant.
- One sub-module, fetch_fifo: synchronous FIFO of fetch_entry_t with push, pop, clear, count, full and empty. Clear takes effect at the same edge, with priority over push and pop.

Test Plan:
- Memory words 0..3 = A,B,C,HALT_WORD; start with out_ready=1 -> out_pc 0,1,2,3 on consecutive cycles, starting 2 cycles after start. Then halted=1, fetch_count=4, no further out_valid.
- out_ready=0 after start -> FIFO fills with PC 0,1; imem_pc holds 2. Raise out_ready -> PC 0,1,2,... in order with no duplicates or skips.
- Redirect to 100 while the FIFO holds PC 5,6 -> out_valid=0 the next cycle, then out_pc=100,101. PC 5 and 6 are never delivered.
- Redirect to 1024 (MEMORY_SIZE=1024) -> error=1, halted=1, FIFO empty. A subsequent start clears error and restarts at PC 0.
- No HALT_WORD in memory with out_ready=1 -> last delivered out_pc=1023, then halted=1. imem_pc stays 1023 and fetch_count=1024.
- rst asserted with 2 entries buffered in RUN -> next cycle out_valid=0, state IDLE, imem_pc=RESET_PC, all outputs at reset values.
